// File: rtl/rtob_core_param.sv
// Real-time output buffer: queues {timestamp, data} words and releases
// each payload on the cycle the system counter equals its timestamp.
//
// Ports:
//   clk, reset (async, active-low)
//   auto_start, flush, write, fifo_din, counter, err_clear : controls/data in
//   rto_out, rto_valid, rto_late : released payload and qualifiers
//   full, empty, occupancy       : FIFO status
//   overflow_error(_data), timestamp_error(_data), drop_count : diagnostics
module rtob_core_param #(
  parameter int TS_WIDTH   = 64,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int THRESHOLD  = 1000,
  parameter int LATE_MODE  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           auto_start,
  input  logic                           flush,
  input  logic                           write,
  input  logic [TS_WIDTH+DATA_WIDTH-1:0] fifo_din,
  input  logic [TS_WIDTH-1:0]            counter,
  input  logic                           err_clear,
  output logic [DATA_WIDTH-1:0]          rto_out,
  output logic                           rto_valid,
  output logic                           rto_late,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           overflow_error,
  output logic                           timestamp_error,
  output logic [TS_WIDTH+DATA_WIDTH-1:0] overflow_error_data,
  output logic [TS_WIDTH+DATA_WIDTH-1:0] timestamp_error_data,
  output logic [15:0]                    drop_count
);

  localparam int DW = TS_WIDTH + DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] THR = OW'(THRESHOLD);

  logic [DW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DW-1:0]         head;
  logic [TS_WIDTH-1:0]   head_ts;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  eval;
  logic                  hit;
  logic                  late;
  logic                  pop;
  logic                  push;
  logic                  ovf;
  logic                  drop;

  assign full      = (occupancy >= THR);
  assign empty     = (occupancy == '0);

  // First-word fall-through head.
  assign head      = mem[rd_ptr];
  assign head_ts   = head[DW-1 -: TS_WIDTH];
  assign head_data = head[DATA_WIDTH-1:0];

  // Flush wins over everything that would touch the queue this cycle.
  assign eval = auto_start && !empty && !flush;
  assign hit  = eval && (head_ts == counter);
  assign late = eval && (head_ts < counter);
  assign pop  = hit || late;
  assign push = write && !full && !flush;
  assign ovf  = write && full && !flush;
  assign drop = late && (LATE_MODE == 0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rto_out   <= '0;
      rto_valid <= 1'b0;
      rto_late  <= 1'b0;
    end else begin
      rto_valid <= 1'b0;
      if (hit) begin
        rto_out   <= head_data;
        rto_valid <= 1'b1;
        rto_late  <= 1'b0;
      end else if (late && (LATE_MODE != 0)) begin
        rto_out   <= head_data;
        rto_valid <= 1'b1;
        rto_late  <= 1'b1;
      end
    end
  end

  // A new error in the same cycle as err_clear survives the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_error       <= 1'b0;
      timestamp_error      <= 1'b0;
      overflow_error_data  <= '0;
      timestamp_error_data <= '0;
      drop_count           <= '0;
    end else begin
      if (ovf) begin
        overflow_error      <= 1'b1;
        overflow_error_data <= fifo_din;
      end else if (err_clear) begin
        overflow_error <= 1'b0;
      end
      if (late) begin
        timestamp_error      <= 1'b1;
        timestamp_error_data <= head;
      end else if (err_clear) begin
        timestamp_error <= 1'b0;
      end
      if (drop) begin
        if (err_clear)
          drop_count <= 16'd1;
        else if (drop_count != 16'hFFFF)
          drop_count <= drop_count + 16'd1;
      end else if (err_clear) begin
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rtob_core_param.sv
// Directed bench for rtob_core_param: a default instance (drop mode,
// depth 1024) and a small late-emit instance (depth 4) share stimulus.
module tb_rtob_core_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        auto_start;
  logic        flush;
  logic        write;
  logic [71:0] fifo_din;
  logic [63:0] counter;
  logic        err_clear;

  logic [7:0]  a_out, b_out;
  logic        a_valid, b_valid, a_late, b_late;
  logic        a_full, b_full, a_empty, b_empty;
  logic [10:0] a_occ;
  logic [2:0]  b_occ;
  logic        a_oerr, b_oerr, a_terr, b_terr;
  logic [71:0] a_odat, b_odat, a_tdat, b_tdat;
  logic [15:0] a_drop, b_drop;

  int checks = 0;
  int passes = 0;
  int vcount;

  always #5 clk = ~clk;

  rtob_core_param u_a (
    .clk(clk), .reset(reset), .auto_start(auto_start), .flush(flush),
    .write(write), .fifo_din(fifo_din), .counter(counter),
    .err_clear(err_clear), .rto_out(a_out), .rto_valid(a_valid),
    .rto_late(a_late), .full(a_full), .empty(a_empty),
    .occupancy(a_occ), .overflow_error(a_oerr),
    .timestamp_error(a_terr), .overflow_error_data(a_odat),
    .timestamp_error_data(a_tdat), .drop_count(a_drop)
  );

  rtob_core_param #(
    .DEPTH(4), .THRESHOLD(4), .LATE_MODE(1)
  ) u_b (
    .clk(clk), .reset(reset), .auto_start(auto_start), .flush(flush),
    .write(write), .fifo_din(fifo_din), .counter(counter),
    .err_clear(err_clear), .rto_out(b_out), .rto_valid(b_valid),
    .rto_late(b_late), .full(b_full), .empty(b_empty),
    .occupancy(b_occ), .overflow_error(b_oerr),
    .timestamp_error(b_terr), .overflow_error_data(b_odat),
    .timestamp_error_data(b_tdat), .drop_count(b_drop)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; auto_start = 1'b0; flush = 1'b0; write = 1'b0;
    fifo_din = '0; counter = '0; err_clear = 1'b0;
    #3;
    chk("rst_occ", a_occ, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_valid", a_valid, 0);
    chk("rst_out", a_out, 0);
    chk("rst_drop", a_drop, 0);
    tick();
    reset = 1'b1;
    tick();

    // Two timed entries released as the counter ramps.
    counter = 64'd90; auto_start = 1'b1;
    write = 1'b1; fifo_din = {64'd100, 8'hA5}; tick();
    fifo_din = {64'd102, 8'h3C}; tick();
    write = 1'b0;
    chk("ramp_occ2", a_occ, 2);
    vcount = 0;
    for (int c = 91; c <= 104; c++) begin
      counter = 64'(c);
      tick();
      if (a_valid) vcount++;
      if (c == 100) begin
        chk("ramp_v100", a_valid, 1);
        chk("ramp_d100", a_out, 8'hA5);
        chk("ramp_occ1", a_occ, 1);
      end
      if (c == 102) begin
        chk("ramp_v102", a_valid, 1);
        chk("ramp_d102", a_out, 8'h3C);
        chk("ramp_late", a_late, 0);
        chk("ramp_occ0", a_occ, 0);
        chk("ramp_empty", a_empty, 1);
      end
    end
    chk("ramp_pulses", vcount, 2);

    // Fill to threshold, then one rejected write.
    auto_start = 1'b0; counter = '0; write = 1'b1;
    for (int i = 0; i < 999; i++) begin
      fifo_din = {64'(1000000 + i), 8'(i)};
      tick();
    end
    chk("fill_nfull", a_full, 0);
    fifo_din = {64'd2000000, 8'h11}; tick();
    chk("fill_full", a_full, 1);
    chk("fill_occ", a_occ, 1000);
    chk("fill_noovf", a_oerr, 0);
    fifo_din = {64'hDEAD, 8'h77}; tick();
    write = 1'b0;
    chk("ovf_flag", a_oerr, 1);
    chk("ovf_data", a_odat, {64'hDEAD, 8'h77});
    chk("ovf_occ", a_occ, 1000);

    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("clr_ovf", a_oerr, 0);

    // Flush with a write to a full buffer: nothing stored, no overflow.
    flush = 1'b1; write = 1'b1; fifo_din = {64'd1, 8'h01}; tick();
    flush = 1'b0; write = 1'b0;
    chk("flush_occ", a_occ, 0);
    chk("flush_empty", a_empty, 1);
    chk("flush_noovf", a_oerr, 0);
    chk("flush_out", a_out, 8'h3C);

    // Late entries: A drops, B emits flagged late.
    counter = 64'd50; auto_start = 1'b1; write = 1'b1;
    fifo_din = {64'd5, 8'hE5}; tick();
    chk("late_a_v1", a_valid, 0);
    fifo_din = {64'd6, 8'hE6}; tick();
    chk("late_a_v2", a_valid, 0);
    chk("late_b_v", b_valid, 1);
    chk("late_b_late", b_late, 1);
    chk("late_b_out", b_out, 8'hE5);
    fifo_din = {64'd7, 8'hE7}; tick();
    chk("late_a_v3", a_valid, 0);
    write = 1'b0; tick();
    chk("late_a_v4", a_valid, 0);
    chk("late_drop", a_drop, 3);
    chk("late_terr", a_terr, 1);
    chk("late_tdat", a_tdat, {64'd7, 8'hE7});
    chk("late_occ", a_occ, 0);
    chk("late_b_drop", b_drop, 0);
    chk("late_b_out7", b_out, 8'hE7);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("clr_drop", a_drop, 0);
    chk("clr_terr", a_terr, 0);
    chk("clr_b_terr", b_terr, 0);

    // Ten write/release steps through the depth-4 instance.
    for (int k = 0; k < 10; k++) begin
      counter = 64'(1999 + k);
      write = 1'b1;
      fifo_din = {64'(2000 + k), 8'(8'hC0 + k)};
      tick();
      if (k >= 1) begin
        chk("wrap_v", b_valid, 1);
        chk("wrap_d", b_out, 8'(8'hC0 + k - 1));
        chk("wrap_late", b_late, 0);
      end
    end
    counter = 64'd2009; write = 1'b0; tick();
    chk("wrap_last", b_out, 8'hC9);
    chk("wrap_empty", b_empty, 1);

    // Asynchronous reset with entries queued.
    auto_start = 1'b0; write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fifo_din = {64'(9000 + i), 8'h5A};
      tick();
    end
    write = 1'b0;
    chk("pre_rst_occ", a_occ, 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_occ", a_occ, 0);
    chk("arst_empty", a_empty, 1);
    chk("arst_out", a_out, 0);
    chk("arst_b_out", b_out, 0);
    chk("arst_tdat", a_tdat, 0);
    chk("arst_odat", a_odat, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
